// File: rtl/stream_demux2.sv
// 1-to-2 valid/ready stream distributor with an independent 2-entry FIFO and wrapping beat counter per output.
// Define STREAM_DEMUX2_ASSERT_EN to compile the protocol checks that drive the sticky o_err flag.
module stream_demux2 #(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    input  logic          i_sel,
    output logic          o_ready,
    output logic          o_a_valid,
    output logic [DW-1:0] o_a_data,
    input  logic          i_a_ready,
    output logic          o_b_valid,
    output logic [DW-1:0] o_b_data,
    input  logic          i_b_ready,
    output logic [CW-1:0] o_a_cnt,
    output logic [CW-1:0] o_b_cnt,
    output logic          o_err
);
    // Index 0 is output A, index 1 is output B throughout.
    logic [1:0][1:0][DW-1:0] mem_q, mem_d;
    logic [1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0][1:0]         occ_q, occ_d;
    logic [1:0][CW-1:0]      cnt_q, cnt_d;
    logic [1:0]              full, push, pop, out_vld, out_rdy;

    always_comb begin
        out_rdy = {i_b_ready, i_a_ready};
        for (int f = 0; f < 2; f++) begin
            full[f]    = (occ_q[f] == 2'd2);
            out_vld[f] = (occ_q[f] != 2'd0);
        end
        // Readiness depends only on the selected FIFO; a pop this cycle does not free space.
        o_ready = i_sel ? !full[0] : !full[1];
        push[0] = i_valid && o_ready && i_sel;
        push[1] = i_valid && o_ready && !i_sel;
        pop     = out_vld & out_rdy;

        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        for (int f = 0; f < 2; f++) begin
            if (push[f]) begin
                mem_d[f][wptr_q[f]] = i_data;
                wptr_d[f]           = ~wptr_q[f];
            end
            if (pop[f]) begin
                rptr_d[f] = ~rptr_q[f];
                cnt_d[f]  = cnt_q[f] + 1'b1;
            end
            occ_d[f] = occ_q[f] + {1'b0, push[f]} - {1'b0, pop[f]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_a_valid = out_vld[0];
    assign o_b_valid = out_vld[1];
    assign o_a_data  = mem_q[0][rptr_q[0]];
    assign o_b_data  = mem_q[1][rptr_q[1]];
    assign o_a_cnt   = cnt_q[0];
    assign o_b_cnt   = cnt_q[1];

`ifdef STREAM_DEMUX2_ASSERT_EN
    logic          stall_q, stall_d, sel_q, sel_d, err_q, err_d;
    logic [DW-1:0] data_q, data_d;
    logic [3:0]    chk;

    always_comb begin
        stall_d = i_valid && !o_ready;
        sel_d   = i_sel;
        data_d  = i_data;
        // A stalled beat must be re-presented unchanged on the next cycle.
        chk[0]  = stall_q && !(i_valid && (i_sel == sel_q) && (i_data == data_q));
        chk[1]  = |(push & full);
        chk[2]  = |(pop & ~out_vld);
        chk[3]  = (occ_q[0] > 2'd2) || (occ_q[1] > 2'd2);
        err_d   = err_q || (|chk);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_q <= 1'b0;
            sel_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            err_q   <= err_d;
            assert (!chk[0]) else $error("stream_demux2: input changed while stalled");
            assert (!chk[1]) else $error("stream_demux2: push into full fifo");
            assert (!chk[2]) else $error("stream_demux2: pop from empty fifo");
            assert (!chk[3]) else $error("stream_demux2: occupancy above 2");
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule
